crc_frame_checker: RTL
======================

# crc_frame_checker

Streaming receive-side CRC checker for byte-serial frames that carry a trailing frame check sequence (FCS). It runs the CRC over every received byte, strips the FCS bytes from the forwarded stream, and reports pass/fail per frame. It sits behind a byte deserializer in link and bench receive paths, as the counterpart to an FCS-appending transmitter. Polynomial parameters match the CRC-8/16/32 models in the dv CRC package, so RTL results check directly against them.

## Interface
Parameters:
- CRC_W, 32, CRC width: 8, 16 or 32. FCS length is N = CRC_W/8 bytes.
- POLY, 32'h04C11DB7, generator polynomial, normal (non-reflected) form, low CRC_W bits used.
- INIT, 32'hFFFFFFFF, register value at frame start.
- REFLECT, 1, 1 = reflected input and register (LSB-first); 0 = MSB-first.
- RESIDUE, 32'hDEBB20E3, register value before xorout after data+FCS for a good frame.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- s_valid_i  in  1  input byte valid.
- s_ready_o  out  1  input byte accepted when valid && ready.
- s_data_i  in  8  input byte, FCS last, in transmitted byte order.
- s_last_i  in  1  final byte of frame (last FCS byte).
- m_valid_o  out  1  payload byte valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  8  payload byte.
- m_last_o  out  1  final payload byte.
- stat_valid_o  out  1  one-cycle frame status strobe.
- stat_ok_o  out  1  frame good; qualified by stat_valid_o.
- stat_short_o  out  1  frame had length ≤ N; qualified by stat_valid_o.
- frame_cnt_o  out  CNT_W  frames completed, saturating.
- err_cnt_o  out  CNT_W  bad or short frames, saturating.

## Operation
- Delay line: N-byte shift register plus fill counter (0..N). It holds the most recent N accepted bytes of the current frame.
- When fill < N, input is absorbed: s_ready_o = 1, m_valid_o = 0, and fill increments.
- When fill = N, input flows through: m_valid_o = s_valid_i and s_ready_o = m_ready_i. On a handshake the oldest byte goes to m_data_o, the new byte shifts in, and m_last_o = s_last_i.
- The transfer that outputs byte L-1-N is the one that accepts input byte L-1, where L is the frame length. That output byte is therefore the last payload byte.
- On an accepted s_last_i, fill returns to 0 and the delay line is cleared.
- CRC register: starts at INIT. On each accepted byte it updates bytewise with POLY, reflected or normal according to REFLECT. This includes FCS bytes.
- On an accepted last byte, the register reloads INIT on the next edge.
- Frame result: ok = (register after last byte == RESIDUE[CRC_W-1:0]) && !short.
- Short frame (L ≤ N): no bytes are forwarded and no m_last_o is emitted. stat_short_o = 1 and stat_ok_o = 0. A frame with L = N is short.
- s_last_i on the first byte (L = 1) is a short frame; the CRC still resets.
- Counters: frame_cnt_o increments on every stat_valid_o. err_cnt_o increments when stat_valid_o && !stat_ok_o. Both saturate at all-ones and never wrap.
- Reset values: s_ready_o = 1 (fill = 0). m_valid_o, m_last_o, stat_valid_o, stat_ok_o and stat_short_o are 0. Counters are 0, the CRC register is INIT and m_data_o is 0.

## Timing
- Payload path is combinational: valid, ready and data pass through in zero cycles while fill = N. There is no added bubble, and full throughput is one byte per cycle.
- Payload is available N input handshakes late.
- Status and flags are registered. stat_valid_o pulses for exactly one cycle, on the cycle after the s_last_i handshake.
- Counters update on the same edge that asserts stat_valid_o.
- Back-to-back frames: byte 0 of the next frame may be accepted on the cycle after last. It uses INIT and fill = 0, and its status strobe does not overlap the previous one.
- Backpressure: with fill = N and m_ready_i = 0, s_ready_o = 0 and no state changes. While fill < N, input is accepted regardless of m_ready_i.
- Reset asserted mid-frame aborts the frame immediately. No status is emitted and a partial payload never gets m_last_o.

## Structure
- Shared package crc_chk_pkg holds:
  - the bytewise next-state function crc_step(crc, byte, poly, width, reflect);
  - named parameter sets for CRC-32/ISO-HDLC, CRC-16/KERMIT and CRC-8/SMBUS, covering POLY, INIT, REFLECT and RESIDUE.
- Sub-module crc_fcs_delay implements the N-deep delay line with fill counter and valid/ready logic.
- The top level contains the CRC register, status flops and counters.

## Test plan
- Good frame: CRC-32 defaults, ASCII "123456789" followed by 0x26 0x39 0xF4 0xCB (0xCBF43926, LSB first), m_ready_i = 1. Required: exactly 9 bytes out, m_last_o on 0x39, stat_ok_o = 1, frame_cnt_o = 1, err_cnt_o = 0.
- Corrupted frame: same frame with payload byte 3 XOR 0x01. Required: 9 bytes still forwarded, stat_ok_o = 0, err_cnt_o = 1.
- Short frame: 3-byte frame, then a 4-byte frame. Required: no m_valid_o, and stat_short_o = 1 for both.
- Random backpressure: 64-byte frames with random m_ready_i and s_valid_i. Required: payload matches the model byte for byte, no loss or duplication, and status identical to the no-backpressure run.
- Back-to-back frames: three frames with zero idle cycles and alternating good/bad FCS. Required: three single-cycle strobes, results good/bad/good.
- Reset mid-frame and saturation:
  - rst_ni asserted after 5 bytes, then a good frame. Required: no strobe for the aborted frame, and the new frame is ok.
  - CNT_W = 4 with 20 bad frames. Required: err_cnt_o holds at 15.

Source files
------------

// File: rtl/crc_chk_pkg.sv
// Shared CRC helpers: bytewise next-state function and named parameter sets.
package crc_chk_pkg;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic        reflect;
    logic [31:0] residue;
  } crc_cfg_t;

  localparam crc_cfg_t CRC32_ISO_HDLC = '{poly: 32'h04C11DB7, init: 32'hFFFFFFFF,
                                          reflect: 1'b1, residue: 32'hDEBB20E3};
  localparam crc_cfg_t CRC16_KERMIT   = '{poly: 32'h00001021, init: 32'h00000000,
                                          reflect: 1'b1, residue: 32'h00000000};
  localparam crc_cfg_t CRC8_SMBUS     = '{poly: 32'h00000007, init: 32'h00000000,
                                          reflect: 1'b0, residue: 32'h00000000};

  // All-ones mask covering the low width bits of a 32-bit container.
  function automatic logic [31:0] crc_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // One byte of CRC update. The register lives in the low width bits; upper bits stay zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data,
                                           input logic [31:0] poly, input int width,
                                           input logic reflect);
    logic [31:0] mask;
    logic [31:0] c;
    logic [31:0] p;
    mask = crc_mask(width);
    p    = '0;
    if (reflect) begin
      // LSB-first: use the bit-reversed polynomial aligned to the register width
      for (int i = 0; i < 32; i++) p[i] = poly[31-i];
      p = p >> (32 - width);
      c = (crc & mask) ^ {24'd0, data};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
    end else begin
      // MSB-first: data enters at the top of the register
      c = (crc & mask) ^ ({24'd0, data} << (width - 8));
      for (int b = 0; b < 8; b++) c = c[width-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
    end
    return c & mask;
  endfunction

endpackage

// File: rtl/crc_fcs_delay.sv
// N-byte delay line that hides the trailing FCS bytes from the downstream stream.
module crc_fcs_delay #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       accept,
  output logic       full
);

  localparam int FILL_W = $clog2(N + 1);

  logic [FILL_W-1:0]  fill_reg;
  logic [N-1:0][7:0]  line_reg;
  logic [N:0][7:0]    line_cat;

  // Index 0 is the newest byte; index N of the concatenation is the oldest, leaving on a flow handshake.
  assign line_cat = {line_reg, s_data};
  assign full     = (fill_reg == FILL_W'(N));
  assign s_ready  = full ? m_ready : 1'b1;
  assign accept   = s_valid && s_ready;
  assign m_valid  = full && s_valid;
  assign m_data   = line_cat[N];
  assign m_last   = full && s_valid && s_last;

  // Fill counter: climbs to N during the first bytes of a frame, returns to 0 after last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_reg <= '0;
    end else if (accept) begin
      if (s_last)     fill_reg <= '0;
      else if (!full) fill_reg <= fill_reg + FILL_W'(1);
    end
  end

  // Shift register: new byte enters on every accepted byte, cleared at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_reg <= '0;
    end else if (accept) begin
      line_reg <= s_last ? '0 : line_cat[N-1:0];
    end
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side FCS checker: strips the FCS, checks the residue, reports per-frame status.
module crc_frame_checker
  import crc_chk_pkg::*;
#(
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             stat_valid_o,
  output logic             stat_ok_o,
  output logic             stat_short_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int          N      = CRC_W / 8;
  localparam logic [31:0] MASK   = crc_mask(CRC_W);
  localparam logic [31:0] INIT_M = INIT & MASK;
  localparam logic [31:0] RES_M  = RESIDUE & MASK;

  logic             accept;
  logic             full;
  logic             frame_done;
  logic             frame_good;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_next;
  logic             stat_valid_reg;
  logic             stat_ok_reg;
  logic             stat_short_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  crc_fcs_delay #(.N(N)) u_delay (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .s_valid (s_valid_i),
    .s_ready (s_ready_o),
    .s_data  (s_data_i),
    .s_last  (s_last_i),
    .m_valid (m_valid_o),
    .m_ready (m_ready_i),
    .m_data  (m_data_o),
    .m_last  (m_last_o),
    .accept  (accept),
    .full    (full)
  );

  // The register value after the last byte includes the FCS, so a good frame lands on the residue.
  assign crc_next   = crc_step(crc_reg, s_data_i, POLY, CRC_W, REFLECT);
  assign frame_done = accept && s_last_i;
  assign frame_good = full && (crc_next == RES_M);

  // CRC register: runs over every accepted byte, restarts from INIT after the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_reg <= INIT_M;
    end else if (accept) begin
      crc_reg <= s_last_i ? INIT_M : crc_next;
    end
  end

  // Status flops: one-cycle strobe with its flags, zero between frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_valid_reg <= 1'b0;
      stat_ok_reg    <= 1'b0;
      stat_short_reg <= 1'b0;
    end else begin
      stat_valid_reg <= frame_done;
      stat_ok_reg    <= frame_done && frame_good;
      stat_short_reg <= frame_done && !full;
    end
  end

  // Saturating statistics counters, updated on the edge that raises the strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else if (frame_done) begin
      if (frame_cnt_reg != '1) frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      if (!frame_good && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign stat_valid_o = stat_valid_reg;
  assign stat_ok_o    = stat_ok_reg;
  assign stat_short_o = stat_short_reg;
  assign frame_cnt_o  = frame_cnt_reg;
  assign err_cnt_o    = err_cnt_reg;

endmodule
